// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: decodes the ID-stage hazard_op into PC / IF/ID / ID/EX
// enable and flush strobes, sequences redirect bubbles, counts stalls/flushes, stall watchdog.
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       hazard_op_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_timeout_o,
  output logic             illegal_op_o
);

  localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned SR_W = $clog2(MAX_STALL + 1);

  localparam logic [1:0] OP_STALL = 2'd1;
  localparam logic [1:0] OP_REDIR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FL_W-1:0]   flush_left_q, flush_left_d;
  logic [SR_W-1:0]   stall_run_q, stall_run_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;
  logic              illegal_q, illegal_d;

  logic              is_flush_s;
  logic              is_stall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  // Classify the cycle: redirect beats an ongoing flush, which beats a stall
  always_comb begin
    is_flush_s = 1'b0;
    is_stall_s = 1'b0;
    if (hazard_op_i == OP_REDIR) begin
      is_flush_s = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      is_flush_s = 1'b1;
    end else if (hazard_op_i == OP_STALL) begin
      is_stall_s = 1'b1;
    end else begin
      is_flush_s = 1'b0;
      is_stall_s = 1'b0;
    end
  end

  // Strobes are same-cycle; reset overrides them so the pipe fills with bubbles
  assign pc_en_o       = rst_ni & ~is_stall_s;
  assign if_id_en_o    = rst_ni & ~is_stall_s;
  assign if_id_flush_o = ~rst_ni | is_flush_s;
  assign id_ex_flush_o = ~rst_ni | is_flush_s | is_stall_s;

  // Next-state for sequencer, watchdog, counters and sticky flags
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    if (hazard_op_i == OP_REDIR) begin
      flush_left_d = FL_W'(FLUSH_CYCLES - 1);
      state_d      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      if (flush_left_q <= FL_W'(1)) begin
        flush_left_d = '0;
        state_d      = ST_RUN;
      end else begin
        flush_left_d = flush_left_q - FL_W'(1);
        state_d      = ST_FLUSH;
      end
    end else if (is_stall_s) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
    end

    if (!is_stall_s) begin
      stall_run_d = '0;
    end else if (stall_run_q >= SR_W'(MAX_STALL)) begin
      stall_run_d = stall_run_q;
    end else begin
      stall_run_d = stall_run_q + SR_W'(1);
    end

    // The cycle that brings the run up to MAX_STALL trips the watchdog
    timeout_d   = timeout_q | (is_stall_s && (stall_run_q >= SR_W'(MAX_STALL - 1)));
    illegal_d   = illegal_q | (hazard_op_i == OP_RSVD);
    stall_cnt_d = sat_inc(stall_cnt_q, is_stall_s);
    flush_cnt_d = sat_inc(flush_cnt_q, is_flush_s);
  end

  // State and statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
      stall_run_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      stall_run_q  <= stall_run_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      timeout_q    <= timeout_d;
      illegal_q    <= illegal_d;
    end
  end

  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
  assign stall_timeout_o = timeout_q;
  assign illegal_op_o    = illegal_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table on a FLUSH_CYCLES=1 instance, hand sequences
// for multi-cycle flush, mid-flush reset and counter saturation on a FLUSH_CYCLES=3 instance.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: FLUSH_CYCLES=1, 32-bit counters
  logic        rst_a;
  logic [1:0]  op_a;
  logic        pc_a, ife_a, iff_a, idf_a, to_a, il_a;
  logic [31:0] sc_a, fc_a;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(4), .CNT_W(32)) u_a (
    .clk_i(clk), .rst_ni(rst_a), .hazard_op_i(op_a),
    .pc_en_o(pc_a), .if_id_en_o(ife_a), .if_id_flush_o(iff_a), .id_ex_flush_o(idf_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a), .stall_timeout_o(to_a), .illegal_op_o(il_a)
  );

  // Instance B: FLUSH_CYCLES=3, 3-bit counters so saturation is reachable
  logic        rst_b;
  logic [1:0]  op_b;
  logic        pc_b, ife_b, iff_b, idf_b, to_b, il_b;
  logic [2:0]  sc_b, fc_b;

  pipeline_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(4), .CNT_W(3)) u_b (
    .clk_i(clk), .rst_ni(rst_b), .hazard_op_i(op_b),
    .pc_en_o(pc_b), .if_id_en_o(ife_b), .if_id_flush_o(iff_b), .id_ex_flush_o(idf_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b), .stall_timeout_o(to_b), .illegal_op_o(il_b)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  strb;   // {pc_en, if_id_en, if_id_flush, id_ex_flush}
    logic [31:0] sc;
    logic [31:0] fc;
    logic        to;
    logic        il;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on B: drive op, check strobes mid-cycle, then registered counters after the edge
  task automatic cyc_b(input logic [1:0] op, input logic [3:0] es, input logic [31:0] esc,
                       input logic [31:0] efc, input string nm);
    op_b = op;
    #3;
    chk({nm, "_strb"}, 32'({pc_b, ife_b, iff_b, idf_b}), 32'(es));
    @(posedge clk);
    #1;
    chk({nm, "_sc"}, 32'(sc_b), esc);
    chk({nm, "_fc"}, 32'(fc_b), efc);
  endtask

  initial begin
    tv[0]  = '{2'd0, 4'b1100, 32'd0,  32'd0, 1'b0, 1'b0};
    tv[1]  = '{2'd1, 4'b0001, 32'd1,  32'd0, 1'b0, 1'b0};
    tv[2]  = '{2'd1, 4'b0001, 32'd2,  32'd0, 1'b0, 1'b0};
    tv[3]  = '{2'd1, 4'b0001, 32'd3,  32'd0, 1'b0, 1'b0};
    tv[4]  = '{2'd0, 4'b1100, 32'd3,  32'd0, 1'b0, 1'b0};
    tv[5]  = '{2'd1, 4'b0001, 32'd4,  32'd0, 1'b0, 1'b0};
    tv[6]  = '{2'd1, 4'b0001, 32'd5,  32'd0, 1'b0, 1'b0};
    tv[7]  = '{2'd2, 4'b1111, 32'd5,  32'd1, 1'b0, 1'b0};
    tv[8]  = '{2'd1, 4'b0001, 32'd6,  32'd1, 1'b0, 1'b0};
    tv[9]  = '{2'd1, 4'b0001, 32'd7,  32'd1, 1'b0, 1'b0};
    tv[10] = '{2'd0, 4'b1100, 32'd7,  32'd1, 1'b0, 1'b0};
    tv[11] = '{2'd3, 4'b1100, 32'd7,  32'd1, 1'b0, 1'b1};
    tv[12] = '{2'd0, 4'b1100, 32'd7,  32'd1, 1'b0, 1'b1};
    tv[13] = '{2'd1, 4'b0001, 32'd8,  32'd1, 1'b0, 1'b1};
    tv[14] = '{2'd1, 4'b0001, 32'd9,  32'd1, 1'b0, 1'b1};
    tv[15] = '{2'd1, 4'b0001, 32'd10, 32'd1, 1'b0, 1'b1};
    tv[16] = '{2'd1, 4'b0001, 32'd11, 32'd1, 1'b1, 1'b1};
    tv[17] = '{2'd0, 4'b1100, 32'd11, 32'd1, 1'b1, 1'b1};
    tv[18] = '{2'd1, 4'b0001, 32'd12, 32'd1, 1'b1, 1'b1};
    tv[19] = '{2'd2, 4'b1111, 32'd12, 32'd2, 1'b1, 1'b1};
    tv[20] = '{2'd2, 4'b1111, 32'd12, 32'd3, 1'b1, 1'b1};
    tv[21] = '{2'd0, 4'b1100, 32'd12, 32'd3, 1'b1, 1'b1};

    rst_a = 1'b0;
    rst_b = 1'b0;
    op_a  = 2'd0;
    op_b  = 2'd0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_strb_a", 32'({pc_a, ife_a, iff_a, idf_a}), 32'(4'b0011));
    chk("rst_strb_b", 32'({pc_b, ife_b, iff_b, idf_b}), 32'(4'b0011));
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    chk("rel_strb_a", 32'({pc_a, ife_a, iff_a, idf_a}), 32'(4'b1100));
    chk("rel_cnt_a", sc_a | fc_a, 32'd0);
    chk("rel_flags_a", 32'({to_a, il_a}), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      op_a = tv[i].op;
      #3;
      chk($sformatf("v%0d_strb", i), 32'({pc_a, ife_a, iff_a, idf_a}), 32'(tv[i].strb));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sc", i), sc_a, tv[i].sc);
      chk($sformatf("v%0d_fc", i), fc_a, tv[i].fc);
      chk($sformatf("v%0d_to", i), 32'(to_a), 32'(tv[i].to));
      chk($sformatf("v%0d_il", i), 32'(il_a), 32'(tv[i].il));
    end

    // Three-cycle redirect bubble; stall requests during it are wrong-path and ignored
    cyc_b(2'd2, 4'b1111, 32'd0, 32'd1, "fl1");
    cyc_b(2'd1, 4'b1111, 32'd0, 32'd2, "fl2");
    cyc_b(2'd1, 4'b1111, 32'd0, 32'd3, "fl3");
    cyc_b(2'd1, 4'b0001, 32'd1, 32'd3, "fl_post_stall");
    cyc_b(2'd0, 4'b1100, 32'd1, 32'd3, "fl_post_run");

    // Reset in the second cycle of a flush
    cyc_b(2'd2, 4'b1111, 32'd1, 32'd4, "rf1");
    op_b = 2'd0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("rf_forced_strb", 32'({pc_b, ife_b, iff_b, idf_b}), 32'(4'b0011));
    chk("rf_forced_cnt", 32'({sc_b, fc_b}), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc_b(2'd0, 4'b1100, 32'd0, 32'd0, "rf_after");

    // Stall counter saturates at all-ones (3 bits)
    for (int i = 1; i <= 9; i++) begin
      cyc_b(2'd1, 4'b0001, (i > 7) ? 32'd7 : 32'(i), 32'd0, $sformatf("sat%0d", i));
    end
    chk("sat_timeout", 32'(to_b), 32'd1);
    cyc_b(2'd0, 4'b1100, 32'd7, 32'd0, "sat_end");
    chk("b_illegal", 32'(il_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
